pc_branch_unit: RTL and testbench

- Program-counter stage that consumes the shifted 16-bit branch offset from the left-shift stage.
- Holds the PC register and advances it by a fixed increment each cycle.
- On a taken branch or jump, redirects the PC and issues a fixed-length pipeline flush.
- Supports stall and halt; sits between the offset shifter/branch-compare logic and instruction fetch.

---
 rtl/pc_branch_unit.sv | 150 +++++++++++++++
 tb/tb_pc_branch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_unit.sv
// Program-counter stage: sequential PC advance, PC-relative branch / absolute jump redirect with a fixed-length flush, stall and halt.
// Latency: redirect input to new pc is 1 cycle; every output is registered, no combinational input->output path.
// Backpressure: stall freezes pc, state, flush and counter; halt parks the unit until reset. Optional macro PC_ALIGN_CHECK_EN rejects odd targets.
module pc_branch_unit #(
    parameter int                WIDTH        = 16,
    parameter logic [WIDTH-1:0]  RESET_PC     = '0,
    parameter int                INC          = 2,
    parameter int                FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             halt,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] offset_shifted,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_addr,
    output logic [WIDTH-1:0] pc,
    output logic             flush,
    output logic             halted,
    output logic             misalign_err
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_FLUSH  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);
    localparam logic [2:0]       FC_W  = 3'(FLUSH_CYCLES);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             flush_q, flush_d;
    logic             halted_q, halted_d;

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] target;
    logic             redirect;

`ifdef PC_ALIGN_CHECK_EN
    logic             misalign_q, misalign_d;
`endif

    // Next-state, next-PC and flush counter; priority halt > stall > jump > branch > increment
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        flush_d  = flush_q;
        halted_d = halted_q;
`ifdef PC_ALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        pc_inc   = pc_q + INC_W;
        // Jump beats branch when both are raised; branch target is relative to the current pc.
        target   = jump ? jump_addr : (pc_q + offset_shifted);
        redirect = jump | branch_taken;

        if (state_q == S_HALTED) begin
            // Parked: every input is ignored until reset.
            flush_d  = 1'b0;
            halted_d = 1'b1;
        end else if (halt) begin
            state_d  = S_HALTED;
            flush_d  = 1'b0;
            cnt_d    = 3'd0;
            halted_d = 1'b1;
        end else if (!stall) begin
            case (state_q)
                S_RUN: begin
                    if (redirect) begin
`ifdef PC_ALIGN_CHECK_EN
                        if (target[0]) begin
                            // Odd target: refuse the redirect, keep fetching sequentially.
                            pc_d       = pc_inc;
                            misalign_d = 1'b1;
                        end else begin
                            pc_d    = target;
                            state_d = S_FLUSH;
                            cnt_d   = FC_W;
                            flush_d = 1'b1;
                        end
`else
                        pc_d    = target;
                        state_d = S_FLUSH;
                        cnt_d   = FC_W;
                        flush_d = 1'b1;
`endif
                    end else begin
                        pc_d = pc_inc;
                    end
                end
                S_FLUSH: begin
                    // Redirect requests here come from squashed instructions and are dropped.
                    pc_d    = pc_inc;
                    cnt_d   = cnt_q - 3'd1;
                    flush_d = (cnt_d != 3'd0);
                    if (cnt_d == 3'd0) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_RUN;
                    cnt_d   = 3'd0;
                    flush_d = 1'b0;
                end
            endcase
        end
    end

    // State, PC and status registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RUN;
            pc_q     <= RESET_PC;
            cnt_q    <= 3'd0;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Sticky misaligned-target flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

    assign pc     = pc_q;
    assign flush  = flush_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
module tb_pc_branch_unit;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        halt;
    logic        branch_taken;
    logic [15:0] offset_shifted;
    logic        jump;
    logic [15:0] jump_addr;
    logic [15:0] pc;
    logic        flush;
    logic        halted;
    logic        misalign_err;

    typedef struct packed {
        logic [15:0] id;
        logic [15:0] pc;
        logic        fl;
        logic        hl;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   errors = 0;
    int   step_id = 0;

    pc_branch_unit #(
        .WIDTH(16),
        .RESET_PC(16'h0000),
        .INC(2),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .halt(halt),
        .branch_taken(branch_taken),
        .offset_shifted(offset_shifted),
        .jump(jump),
        .jump_addr(jump_addr),
        .pc(pc),
        .flush(flush),
        .halted(halted),
        .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are sampled 1 time unit after each rising clock edge or reset assertion
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if ({pc, flush, halted, misalign_err} !== {e.pc, e.fl, e.hl, e.mis}) begin
                    errors++;
                    $display("FAIL step%0d: got pc=%h flush=%b halted=%b mis=%b, expected pc=%h flush=%b halted=%b mis=%b",
                             e.id, pc, flush, halted, misalign_err, e.pc, e.fl, e.hl, e.mis);
                end
            end
        end
    end

    // One clock of stimulus plus the outputs expected after the following rising edge
    task automatic cyc(input logic st, input logic hl, input logic br, input logic [15:0] off,
                       input logic jp, input logic [15:0] ja,
                       input logic [15:0] epc, input logic efl, input logic ehl, input logic emis);
        exp_t e;
        @(negedge clk);
        stall          = st;
        halt           = hl;
        branch_taken   = br;
        offset_shifted = off;
        jump           = jp;
        jump_addr      = ja;
        step_id++;
        e = '{id: 16'(step_id), pc: epc, fl: efl, hl: ehl, mis: emis};
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [15:0] epc, input logic efl);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, epc, efl, 1'b0, 1'b0);
    endtask

    // Assert reset between clock edges and expect reset values straight away
    task automatic async_reset();
        exp_t e;
        @(posedge clk);
        #3;
        step_id++;
        e = '{id: 16'(step_id), pc: 16'h0000, fl: 1'b0, hl: 1'b0, mis: 1'b0};
        exp_q.push_back(e);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        stall = 1'b0; halt = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        offset_shifted = 16'h0; jump_addr = 16'h0;

        // Reset state while rst_n is held low
        idle(16'h0000, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Sequential increment after reset release
        idle(16'h0002, 1'b0);
        idle(16'h0004, 1'b0);
        idle(16'h0006, 1'b0);
        idle(16'h0008, 1'b0);
        idle(16'h000A, 1'b0);
        idle(16'h000C, 1'b0);
        idle(16'h000E, 1'b0);
        idle(16'h0010, 1'b0);

        // Branch 0x10 + 100 -> 0x74, two flush cycles
        cyc(0, 0, 1, 16'd100, 0, 16'h0, 16'h0074, 1, 0, 0);
        idle(16'h0076, 1'b1);
        idle(16'h0078, 1'b0);

        // Reach 0x20 through a jump to 0x1C
        cyc(0, 0, 0, 16'h0, 1, 16'h001C, 16'h001C, 1, 0, 0);
        idle(16'h001E, 1'b1);
        idle(16'h0020, 1'b0);

        // Jump and branch together: jump wins; branch during flush is ignored
        cyc(0, 0, 1, 16'd2500, 1, 16'h0400, 16'h0400, 1, 0, 0);
        cyc(0, 0, 1, 16'h0100, 0, 16'h0, 16'h0402, 1, 0, 0);
        idle(16'h0404, 1'b0);

        // Negative offset: 0x0008 + 0xFFF8 -> 0x0000
        cyc(0, 0, 0, 16'h0, 1, 16'h0004, 16'h0004, 1, 0, 0);
        idle(16'h0006, 1'b1);
        idle(16'h0008, 1'b0);
        cyc(0, 0, 1, 16'hFFF8, 0, 16'h0, 16'h0000, 1, 0, 0);
        idle(16'h0002, 1'b1);
        idle(16'h0004, 1'b0);

        // Increment wraps 0xFFFE -> 0x0000
        cyc(0, 0, 0, 16'h0, 1, 16'hFFFA, 16'hFFFA, 1, 0, 0);
        idle(16'hFFFC, 1'b1);
        idle(16'hFFFE, 1'b0);
        idle(16'h0000, 1'b0);

        // Stall three cycles mid-flush: everything frozen, flush still totals two live cycles
        cyc(0, 0, 1, 16'h0020, 0, 16'h0, 16'h0020, 1, 0, 0);
        cyc(1, 0, 0, 16'h0, 0, 16'h0, 16'h0020, 1, 0, 0);
        cyc(1, 0, 0, 16'h0, 0, 16'h0, 16'h0020, 1, 0, 0);
        cyc(1, 0, 0, 16'h0, 0, 16'h0, 16'h0020, 1, 0, 0);
        idle(16'h0022, 1'b1);
        idle(16'h0024, 1'b0);
        idle(16'h0026, 1'b0);
        // Stall in RUN, and stall outranks a jump
        cyc(1, 0, 0, 16'h0, 0, 16'h0, 16'h0026, 0, 0, 0);
        cyc(1, 0, 0, 16'h0, 1, 16'h0300, 16'h0026, 0, 0, 0);

        // Halt during flush; HALTED ignores redirects and dropping halt
        cyc(0, 0, 0, 16'h0, 1, 16'h0100, 16'h0100, 1, 0, 0);
        cyc(1, 1, 0, 16'h0, 0, 16'h0, 16'h0100, 0, 1, 0);
        cyc(0, 0, 1, 16'h0040, 1, 16'h0200, 16'h0100, 0, 1, 0);
        idle(16'h0100, 1'b0);
        exp_q[exp_q.size()-1].hl = 1'b1;

        // Asynchronous reset mid-clock clears the halted unit
        async_reset();
        idle(16'h0002, 1'b0);

        // Odd branch target: rejected with alignment check, taken without it
        if (ALIGN) begin
            cyc(0, 0, 1, 16'd5, 0, 16'h0, 16'h0004, 0, 0, 1);
            idle(16'h0006, 1'b0);
            exp_q[exp_q.size()-1].mis = 1'b1;
            idle(16'h0008, 1'b0);
            exp_q[exp_q.size()-1].mis = 1'b1;
        end else begin
            cyc(0, 0, 1, 16'd5, 0, 16'h0, 16'h0007, 1, 0, 0);
            idle(16'h0009, 1'b1);
            idle(16'h000B, 1'b0);
        end

        // Reset clears the sticky flag
        async_reset();

        #10;
        tests++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
